// File: rtl/timing_stress_gen.sv
// Timing-closure stress generator: LFSR-driven deep combinational chains, XOR-reduced into a rotate-XOR signature.
// Latency: PIPE_STAGES+1 cycles from stimulus issue to the led/signature update (PIPE_STAGES = (CHAIN_LENGTH-1)/PIPE_EVERY, or 0).
// Backpressure: none; once started a run is free-running, and start is ignored while busy.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        begin a run (accepted in IDLE or DONE only)
//   i_mode         chain function, sampled at start (3 = frozen stimulus)
//   i_seed         LFSR/signature seed, sampled at start (0 behaves as 1)
//   i_run_cycles   number of stimulus words, sampled at start
//   o_busy         high in RUN and DRAIN
//   o_done         high in DONE
//   o_signature    accumulated rotate-XOR signature
//   o_led          registered XOR reduction of all chain results
//
// Optional macro TIMING_STRESS_SELFCHECK_EN: builds a duplicate of chain 0 and folds
// any mismatch between the two copies into signature bit SIG_WIDTH-1 at DONE.

module timing_stress_gen #(
  parameter int NUM_CHAINS   = 200,
  parameter int CHAIN_LENGTH = 100,
  parameter int PIPE_EVERY   = 0,
  parameter int SIG_WIDTH    = 32
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [1:0]           i_mode,
  input  logic [31:0]          i_seed,
  input  logic [15:0]          i_run_cycles,
  output logic                 o_busy,
  output logic                 o_done,
  output logic [SIG_WIDTH-1:0] o_signature,
  output logic                 o_led
);

  localparam int PIPE_STAGES = (PIPE_EVERY == 0) ? 0 : (CHAIN_LENGTH - 1) / PIPE_EVERY;
  localparam int PE_DIV      = (PIPE_EVERY == 0) ? 1 : PIPE_EVERY;
`ifdef TIMING_STRESS_SELFCHECK_EN
  localparam int NUM_BUILT   = NUM_CHAINS + 1;
`else
  localparam int NUM_BUILT   = NUM_CHAINS;
`endif
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_t;

  state_t               r_state, w_state_nxt;
  logic [15:0]          r_cnt;
  logic [1:0]           r_mode;
  logic [31:0]          r_lfsr;
  logic [SIG_WIDTH-1:0] r_sig;
  logic                 r_led;

  logic                 w_accept, w_issue, w_inflight, w_vld_end, w_red;
  logic [31:0]          w_seed_eff, w_lfsr_nxt;
  logic [SIG_WIDTH-1:0] w_seed_sig, w_sig_nxt;
  logic [31:0]          w_seg_stim [PIPE_STAGES+1];
  logic [PIPE_STAGES:0] w_seg_vld;
  logic [NUM_BUILT-1:0] w_chain_out;

  // A zero seed is coerced once here so the LFSR and the signature both see
  // the same effective seed; seed 0 and seed 1 then give identical runs.
  assign w_seed_eff = (i_seed == 32'd0) ? 32'd1 : i_seed;

  if (SIG_WIDTH > 32) begin : g_seed_wide
    assign w_seed_sig = {{(SIG_WIDTH-32){1'b0}}, w_seed_eff};
  end else begin : g_seed_narrow
    assign w_seed_sig = w_seed_eff[SIG_WIDTH-1:0];
  end

  assign w_lfsr_nxt = (r_lfsr >> 1) ^ (r_lfsr[0] ? LFSR_TAPS : 32'd0);

  // ---------------- FSM ----------------
  assign w_accept = i_start && (r_state == ST_IDLE || r_state == ST_DONE);
  assign w_issue  = (r_state == ST_RUN);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: if (i_start) w_state_nxt = (i_run_cycles == 16'd0) ? ST_DRAIN : ST_RUN;
      ST_RUN:           if (r_cnt == 16'd1) w_state_nxt = ST_DRAIN;  // r_cnt counts words still to issue, this one included
      ST_DRAIN:         if (!w_inflight) w_state_nxt = ST_DONE;
      default:          w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_busy      = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign o_done      = (r_state == ST_DONE);
  assign o_signature = r_sig;
  assign o_led       = r_led;

  // ---------------- Stimulus / valid pipeline ----------------
  // Segment k holds the stimulus word and valid bit that chain stages after the k-th cut compute on.
  assign w_seg_stim[0] = (r_mode == 2'd3) ? 32'd0 : r_lfsr;
  assign w_seg_vld[0]  = w_issue;

  for (genvar k = 1; k <= PIPE_STAGES; k++) begin : g_seg
    logic [31:0] r_stim;
    logic        r_vld;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_stim <= '0;
        r_vld  <= 1'b0;
      end else begin
        r_stim <= w_seg_stim[k-1];
        r_vld  <= w_seg_vld[k-1];
      end
    end
    assign w_seg_stim[k] = r_stim;
    assign w_seg_vld[k]  = r_vld;
  end

  // Segment 0 is the issue itself; only the registered segments count as in flight.
  assign w_inflight = |(w_seg_vld >> 1);
  assign w_vld_end  = w_seg_vld[PIPE_STAGES];

  // ---------------- Chains ----------------
  for (genvar c = 0; c < NUM_BUILT; c++) begin : g_chain
    localparam int IDX = (c >= NUM_CHAINS) ? 0 : c;  // the extra chain, if built, replicates chain 0
    for (genvar j = 0; j < CHAIN_LENGTH; j++) begin : g_stage
      (* keep *) logic w_s;
      if (j == 0) begin : g_first
        assign w_s = w_seg_stim[0][IDX % 32] ^ w_seg_stim[0][(IDX + 5) % 32];
      end else begin : g_next
        localparam int SEG = (PIPE_EVERY == 0) ? 0 : j / PE_DIV;
        logic w_prev, w_a, w_b;
        if (PIPE_EVERY != 0 && (j % PE_DIV) == 0) begin : g_cut
          (* keep *) logic r_q;
          always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_q <= 1'b0;
            else          r_q <= g_stage[j-1].w_s;
          end
          assign w_prev = r_q;
        end else begin : g_wire
          assign w_prev = g_stage[j-1].w_s;
        end
        assign w_a = w_seg_stim[SEG][j % 32];
        assign w_b = w_seg_stim[SEG][(j + 3) % 32];
        // Mode 3 feeds an all-zero stimulus, so any function leaves the chain at 0.
        assign w_s = (r_mode == 2'd0) ? ((w_prev & w_a) ^ (w_prev | w_b)) :
                     (r_mode == 2'd2) ? (w_prev ^ (w_a & w_b)) :
                                        (w_prev ^ w_a);
      end
    end
    assign w_chain_out[c] = g_stage[CHAIN_LENGTH-1].w_s;
  end

  assign w_red     = ^w_chain_out[NUM_CHAINS-1:0];
  assign w_sig_nxt = {r_sig[SIG_WIDTH-2:0], r_sig[SIG_WIDTH-1]} ^ {{(SIG_WIDTH-1){1'b0}}, w_red};

`ifdef TIMING_STRESS_SELFCHECK_EN
  logic r_err;
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                                     r_err <= 1'b0;
    else if (w_accept)                                                r_err <= 1'b0;
    else if (w_vld_end && (w_chain_out[NUM_CHAINS] != w_chain_out[0])) r_err <= 1'b1;
  end
`endif

  // ---------------- State and datapath registers ----------------
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
      r_mode  <= 2'd0;
      r_lfsr  <= 32'd1;
      r_sig   <= '0;
      r_led   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_cnt  <= i_run_cycles;
        r_mode <= i_mode;
        r_lfsr <= w_seed_eff;
        r_sig  <= w_seed_sig;
      end else begin
        if (w_issue) begin
          r_cnt <= r_cnt - 16'd1;
          if (r_mode != 2'd3) r_lfsr <= w_lfsr_nxt;
        end
        if (w_vld_end) begin
          r_led <= w_red;
          r_sig <= w_sig_nxt;
        end
`ifdef TIMING_STRESS_SELFCHECK_EN
        else if (r_state == ST_DRAIN && !w_inflight) begin
          r_sig[SIG_WIDTH-1] <= r_sig[SIG_WIDTH-1] | r_err;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_timing_stress_gen.sv
// Bench for timing_stress_gen: three builds (PIPE_EVERY 0, 10, 25) share one stimulus
// and are each compared against a word-level reference model of the chain fabric.
module tb_timing_stress_gen;

  localparam int NC = 48;
  localparam int CL = 100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [1:0]  mode;
  logic [31:0] seed;
  logic [15:0] run_cycles;
  logic [2:0]  busy, done, led;
  logic [31:0] sig [3];

  int   n_checks = 0;
  int   n_errors = 0;
  logic m_led = 1'b0;
  int   last_busy [3];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int PE = (k == 0) ? 0 : (k == 1) ? 10 : 25;
    timing_stress_gen #(.NUM_CHAINS(NC), .CHAIN_LENGTH(CL), .PIPE_EVERY(PE), .SIG_WIDTH(32)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_mode       (mode),
      .i_seed       (seed),
      .i_run_cycles (run_cycles),
      .o_busy       (busy[k]),
      .o_done       (done[k]),
      .o_signature  (sig[k]),
      .o_led        (led[k])
    );
  end

  function automatic int lat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 10 : 4;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Final value of one chain, given its stage-0 value and the stimulus word.
  function automatic logic chain_end(input logic s0, input logic [31:0] stim, input logic [1:0] md);
    logic s, a, b;
    s = s0;
    for (int j = 1; j < CL; j++) begin
      a = stim[j % 32];
      b = stim[(j + 3) % 32];
      case (md)
        2'd0:    s = (s & a) ^ (s | b);
        2'd1:    s = s ^ a;
        2'd2:    s = s ^ (a & b);
        default: s = 1'b0;
      endcase
    end
    return s;
  endfunction

  // Chains differ only in their stage-0 value, so evaluate both outcomes once and tally.
  function automatic logic word_red(input logic [31:0] stim, input logic [1:0] md);
    logic f0, f1, r;
    f0 = chain_end(1'b0, stim, md);
    f1 = chain_end(1'b1, stim, md);
    r  = 1'b0;
    for (int i = 0; i < NC; i++) r ^= (stim[i % 32] ^ stim[(i + 5) % 32]) ? f1 : f0;
    return r;
  endfunction

  task automatic model_run(input logic [31:0] sd, input logic [1:0] md, input int n, output logic [31:0] s);
    logic [31:0] lfsr, stim;
    logic        red;
    lfsr = (sd == 32'd0) ? 32'd1 : sd;
    s    = lfsr;
    for (int t = 0; t < n; t++) begin
      stim  = (md == 2'd3) ? 32'd0 : lfsr;
      red   = word_red(stim, md);
      s     = {s[30:0], s[31]} ^ {31'd0, red};
      m_led = red;
      if (md != 2'd3) lfsr = lfsr[0] ? ((lfsr >> 1) ^ 32'h8020_0003) : (lfsr >> 1);
    end
  endtask

  task automatic do_run(input logic [31:0] sd, input logic [1:0] md, input int n, input bit poke, input string tag);
    logic [31:0] exp_sig;
    int cnt [3];
    int fd [3];
    int cyc;
    int exp_busy;
    model_run(sd, md, n, exp_sig);
    @(negedge clk);
    seed = sd; mode = md; run_cycles = 16'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin cnt[k] = 0; fd[k] = -1; end
    cyc = 0;
    while (cyc < n + 64) begin
      for (int k = 0; k < 3; k++) begin
        if (busy[k]) cnt[k]++;
        if (done[k] && fd[k] < 0) fd[k] = cyc;
      end
      if (&done) break;
      start = (poke && cyc == 2);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_busy = (n == 0) ? 1 : n + lat(k);
      last_busy[k] = cnt[k];
      check_eq($sformatf("%s/busy_cycles%0d", tag, k), 32'(cnt[k]), 32'(exp_busy));
      check_eq($sformatf("%s/done_at%0d", tag, k), 32'(fd[k]), 32'(exp_busy));
      check_eq($sformatf("%s/sig%0d", tag, k), sig[k], exp_sig);
      check_eq($sformatf("%s/led%0d", tag, k), {31'd0, led[k]}, {31'd0, m_led});
    end
  endtask

  task automatic check_reset(input string tag);
    for (int k = 0; k < 3; k++) begin
      check_eq($sformatf("%s/busy%0d", tag, k), {31'd0, busy[k]}, 32'd0);
      check_eq($sformatf("%s/done%0d", tag, k), {31'd0, done[k]}, 32'd0);
      check_eq($sformatf("%s/sig%0d", tag, k), sig[k], 32'd0);
      check_eq($sformatf("%s/led%0d", tag, k), {31'd0, led[k]}, 32'd0);
    end
  endtask

  initial begin
    logic [31:0] s0;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; seed = 32'd0; run_cycles = 16'd0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b1;

    do_run(32'h0000_0001, 2'd3, 8, 1'b0, "frozen");
    check_eq("frozen_sig_const", sig[0], 32'h0000_0100);
    check_eq("frozen_led_const", {31'd0, led[0]}, 32'd0);

    do_run(32'hDEAD_BEEF, 2'd0, 0, 1'b0, "zero_run");
    check_eq("zero_run_sig_const", sig[2], 32'hDEAD_BEEF);

    do_run($urandom, 2'd1, 16, 1'b0, "timing");
    check_eq("timing_busy_l4", 32'(last_busy[2]), 32'd20);

    for (int m = 0; m < 3; m++) begin
      do_run(32'h1234_5678, 2'(m), 1000, 1'b0, $sformatf("equiv_m%0d", m));
      check_eq($sformatf("equiv_m%0d/pe10_vs_pe0", m), sig[1], sig[0]);
      check_eq($sformatf("equiv_m%0d/pe25_vs_pe0", m), sig[2], sig[0]);
    end

    do_run(32'hCAFE_F00D, 2'd2, 30, 1'b1, "start_poke");

    for (int m = 0; m < 4; m++) begin
      do_run(32'd0, 2'(m), 12, 1'b0, $sformatf("seed0_m%0d", m));
      s0 = sig[0];
      do_run(32'd1, 2'(m), 12, 1'b0, $sformatf("seed1_m%0d", m));
      check_eq($sformatf("seed0_vs_seed1_m%0d", m), s0, sig[0]);
    end

    repeat (8) do_run($urandom, 2'($urandom_range(0, 3)), $urandom_range(0, 40), 1'b0, "rnd");

    // Reset in the middle of a long run.
    @(negedge clk);
    seed = $urandom; mode = 2'd0; run_cycles = 16'd100; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check_reset("mid_reset");
    rst_n = 1'b1;
    m_led = 1'b0;
    do_run($urandom, 2'd0, 4, 1'b0, "post_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
